bnn_fc_sequencer: RTL and testbench

- Time-multiplexed controller for one binarized fully-connected layer.
- Runs a single CHUNK-wide XNOR-popcount lane over all OUTPUT_DIM neurons.
- Accepts one binary activation vector, streams weight rows chunk-by-chunk from an external weight RAM, and accumulates agreement counts.
- Emits one signed pre-activation per neuron over a valid/ready stream; sits between the activation binarizer and the next layer's input buffer.

---
 rtl/bnn_fc_sequencer_if.sv | 37 +++
 rtl/bnn_fc_sequencer.sv | 130 +++++++++++++
 tb/tb_bnn_fc_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bnn_fc_sequencer_if.sv
// Handshake/bus bundle for the binarized FC-layer sequencer: activation input,
// weight RAM read port and result stream.
interface bnn_fc_sequencer_if #(
    parameter int INPUT_DIM  = 64,
    parameter int OUTPUT_DIM = 16,
    parameter int CHUNK      = 16,
    parameter int BIT_WIDTH  = 8
) ();
    localparam int NCHUNK = INPUT_DIM / CHUNK;
    localparam int AW     = $clog2(OUTPUT_DIM * NCHUNK);
    localparam int NW     = $clog2(OUTPUT_DIM);

    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [INPUT_DIM-1:0] in_vec_i;
    logic                 w_rd_o;
    logic [AW-1:0]        w_addr_o;
    logic [CHUNK-1:0]     w_data_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [NW-1:0]        out_idx_o;
    logic [BIT_WIDTH-1:0] out_val_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (
        input  in_valid_i, in_vec_i, w_data_i, out_ready_i,
        output in_ready_o, w_rd_o, w_addr_o, out_valid_o, out_idx_o, out_val_o,
        busy_o, done_o
    );

    modport slave (
        output in_valid_i, in_vec_i, w_data_i, out_ready_i,
        input  in_ready_o, w_rd_o, w_addr_o, out_valid_o, out_idx_o, out_val_o,
        busy_o, done_o
    );
endinterface

// File: rtl/bnn_fc_sequencer.sv
// Time-multiplexed XNOR-popcount sequencer for one binarized FC layer: one
// CHUNK-wide lane walks every neuron's weight row and emits 2*popcount-INPUT_DIM.
module bnn_fc_sequencer #(
    parameter int INPUT_DIM  = 64,
    parameter int OUTPUT_DIM = 16,
    parameter int CHUNK      = 16,
    parameter int BIT_WIDTH  = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    bnn_fc_sequencer_if.master bus
);
    localparam int NCHUNK = INPUT_DIM / CHUNK;
    localparam int AW     = $clog2(OUTPUT_DIM * NCHUNK);
    localparam int NW     = $clog2(OUTPUT_DIM);
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int ACCW   = $clog2(INPUT_DIM + 1);
    localparam int PCW    = $clog2(CHUNK + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, EMIT} state_t;

    state_t               state;
    logic [INPUT_DIM-1:0] vec;
    logic [NW-1:0]        neuron;
    logic [CW-1:0]        chunk, chunk_d;
    logic [ACCW-1:0]      acc, acc_nxt;
    logic [CHUNK-1:0]     agree;
    logic [BIT_WIDTH-1:0] res;
    // vld_pipe[0]: read issued this cycle; vld_pipe[1]: its data is on w_data_i
    logic [1:0]           vld_pipe;
    logic [AW-1:0]        w_addr;
    logic                 out_valid, busy, done, in_ready;
    logic [NW-1:0]        out_idx;
    logic [BIT_WIDTH-1:0] out_val;

    function automatic logic [PCW-1:0] popcnt(input logic [CHUNK-1:0] x);
        logic [PCW-1:0] s;
        s = '0;
        for (int k = 0; k < CHUNK; k++) s += PCW'(x[k]);
        return s;
    endfunction

    function automatic logic [AW-1:0] row_base(input logic [NW-1:0] n);
        return AW'(int'(n) * NCHUNK);
    endfunction

    always_comb begin
        agree   = ~(bus.w_data_i ^ vec[int'(chunk_d)*CHUNK +: CHUNK]);
        acc_nxt = acc + (vld_pipe[1] ? ACCW'(popcnt(agree)) : '0);
        // Modulo-2^BIT_WIDTH arithmetic lands on the correct signed value.
        res     = BIT_WIDTH'({acc_nxt, 1'b0}) - BIT_WIDTH'(INPUT_DIM);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            vec       <= '0;
            neuron    <= '0;
            chunk     <= '0;
            chunk_d   <= '0;
            acc       <= '0;
            vld_pipe  <= '0;
            w_addr    <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_val   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            done        <= 1'b0;
            vld_pipe[1] <= vld_pipe[0];
            chunk_d     <= chunk;
            acc         <= acc_nxt;
            case (state)
                IDLE: if (bus.in_valid_i) begin
                    vec         <= bus.in_vec_i;
                    neuron      <= '0;
                    chunk       <= '0;
                    acc         <= '0;
                    vld_pipe[0] <= 1'b1;
                    w_addr      <= '0;
                    in_ready    <= 1'b0;
                    busy        <= 1'b1;
                    state       <= RUN;
                end
                RUN: if (chunk == CW'(NCHUNK - 1)) begin
                    vld_pipe[0] <= 1'b0;
                    w_addr      <= '0;
                    state       <= DRAIN;
                end else begin
                    chunk  <= chunk + CW'(1);
                    w_addr <= w_addr + AW'(1);
                end
                DRAIN: begin
                    out_val   <= res;
                    out_idx   <= neuron;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: if (bus.out_ready_i) begin
                    out_valid <= 1'b0;
                    if (neuron == NW'(OUTPUT_DIM - 1)) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        neuron      <= neuron + NW'(1);
                        chunk       <= '0;
                        acc         <= '0;
                        vld_pipe[0] <= 1'b1;
                        w_addr      <= row_base(neuron + NW'(1));
                        state       <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.w_rd_o      = vld_pipe[0];
    assign bus.w_addr_o    = w_addr;
    assign bus.out_valid_o = out_valid;
    assign bus.out_idx_o   = out_idx;
    assign bus.out_val_o   = out_val;
    assign bus.busy_o      = busy;
    assign bus.done_o      = done;
endmodule

// File: tb/tb_bnn_fc_sequencer.sv
// Scoreboard bench for bnn_fc_sequencer: directed layers pushed as expected
// results, a negedge monitor pops and compares each accepted output.
module tb_bnn_fc_sequencer;
    localparam int IN = 64, OD = 16, CH = 16, BW = 8;
    localparam int NC = IN / CH;
    localparam int NW = $clog2(OD);

    typedef struct packed {
        logic [NW-1:0] idx;
        logic [BW-1:0] val;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bnn_fc_sequencer_if #(.INPUT_DIM(IN), .OUTPUT_DIM(OD), .CHUNK(CH), .BIT_WIDTH(BW)) bus ();
    bnn_fc_sequencer #(.INPUT_DIM(IN), .OUTPUT_DIM(OD), .CHUNK(CH), .BIT_WIDTH(BW)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    logic [CH-1:0] wmem [OD*NC];
    always @(posedge clk) if (bus.w_rd_o) bus.w_data_i <= wmem[bus.w_addr_o];

    res_t exp_q[$];
    int n_cmp = 0, n_err = 0, cyc = 0, accept_edge = 0, exp_lat = 0, n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        res_t r;
        if (!rst) begin
            if (bus.in_valid_i && bus.in_ready_o) accept_edge = cyc + 1;
            if (!bus.w_rd_o) chk("addr_idle", int'(bus.w_addr_o), 0);
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: idx %0d val %0d with empty queue",
                             bus.out_idx_o, $signed(bus.out_val_o));
                end else begin
                    r = exp_q.pop_front();
                    chk("out_idx", int'(bus.out_idx_o), int'(r.idx));
                    chk("out_val", int'($signed(bus.out_val_o)), int'($signed(r.val)));
                end
            end
            if (bus.done_o) begin
                n_done++;
                chk("done_latency", cyc - accept_edge, exp_lat);
                chk("done_in_ready", int'(bus.in_ready_o), 1);
                chk("done_pending", exp_q.size(), 0);
            end
        end
    end

    task automatic push(input int n, input int v);
        res_t r;
        r.idx = NW'(n);
        r.val = BW'(v);
        exp_q.push_back(r);
    endtask

    task automatic start(input logic [IN-1:0] v);
        @(posedge clk); #1;
        bus.in_vec_i   = v;
        bus.in_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int nd, t;
        nd = n_done;
        t  = 0;
        while (n_done == nd && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) timeout("wait_done");
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_read(input int a);
        int t;
        t = 0;
        @(negedge clk);
        while (!(bus.w_rd_o && int'(bus.w_addr_o) == a) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) timeout("wait_read");
    endtask

    task automatic fill_aa();
        for (int i = 0; i < OD*NC; i++) wmem[i] = 16'hAAAA;
        wmem[3*NC] = 16'h5555;
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_vec_i    = '0;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < OD*NC; i++) wmem[i] = '1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready_o), 1);
        chk("rst_w_rd", int'(bus.w_rd_o), 0);
        chk("rst_out_valid", int'(bus.out_valid_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_done", int'(bus.done_o), 0);
        rst = 1'b0;

        // All-ones against all-ones RAM, plus an ignored in_valid pulse mid-layer
        exp_lat = 96;
        for (int n = 0; n < OD; n++) push(n, 64);
        start('1);
        repeat (10) @(posedge clk);
        #1;
        chk("busy_mid", int'(bus.busy_o), 1);
        bus.in_vec_i   = '0;
        bus.in_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        wait_done();
        chk("idle_in_ready", int'(bus.in_ready_o), 1);

        // All-ones against all-zero RAM
        for (int i = 0; i < OD*NC; i++) wmem[i] = '0;
        for (int n = 0; n < OD; n++) push(n, -64);
        start('1);
        wait_done();

        // Alternating pattern, one inverted chunk on neuron 3
        fill_aa();
        for (int n = 0; n < OD; n++) push(n, (n == 3) ? 32 : 64);
        start({4{16'hAAAA}});
        wait_done();

        // Backpressure on neuron 2's result
        exp_lat = 101;
        for (int n = 0; n < OD; n++) push(n, (n == 3) ? 32 : 64);
        start({4{16'hAAAA}});
        wait_read(2*NC + NC - 1);
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!bus.out_valid_o && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) timeout("wait_emit");
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", int'(bus.out_valid_o), 1);
            chk("hold_idx", int'(bus.out_idx_o), 2);
            chk("hold_val", int'($signed(bus.out_val_o)), 64);
            chk("hold_w_rd", int'(bus.w_rd_o), 0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready_i = 1'b1;
        wait_done();

        // Reset during neuron 7's RUN, then a fresh layer
        for (int n = 0; n < OD; n++) push(n, (n == 3) ? 32 : 64);
        start({4{16'hAAAA}});
        wait_read(7*NC + 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_in_ready", int'(bus.in_ready_o), 1);
        chk("mid_rst_w_rd", int'(bus.w_rd_o), 0);
        chk("mid_rst_w_addr", int'(bus.w_addr_o), 0);
        chk("mid_rst_out_valid", int'(bus.out_valid_o), 0);
        chk("mid_rst_out_idx", int'(bus.out_idx_o), 0);
        chk("mid_rst_out_val", int'(bus.out_val_o), 0);
        chk("mid_rst_busy", int'(bus.busy_o), 0);
        chk("mid_rst_done", int'(bus.done_o), 0);
        exp_q.delete();
        rst = 1'b0;

        // Neuron n holds n set bits per chunk: 4n agreements -> 8n-64
        for (int n = 0; n < OD; n++)
            for (int c = 0; c < NC; c++) wmem[n*NC + c] = CH'((32'd1 << n) - 1);
        exp_lat = 96;
        for (int n = 0; n < OD; n++) push(n, 8*n - 64);
        start('1);
        wait_done();

        chk("done_count", n_done, 5);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
